// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router packet controller: state encoding
// and destination address constants.
// Optional feature macro: ROUTER_FSM_ADDR3_DROP_EN adds the DROP_PACKET state.
package router_pkg;

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    WAIT_TILL_EMPTY    = 4'd1,
    LOAD_FIRST_DATA    = 4'd2,
    LOAD_DATA          = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    LOAD_PARITY        = 4'd6,
`ifdef ROUTER_FSM_ADDR3_DROP_EN
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PACKET        = 4'd8
`else
    CHECK_PARITY_ERROR = 4'd7
`endif
  } state_t;

  localparam logic [1:0] ADDR_0       = 2'd0;
  localparam logic [1:0] ADDR_1       = 2'd1;
  localparam logic [1:0] ADDR_2       = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

endpackage

// File: rtl/router_fsm_port_sel.sv
// Selects the empty flag and soft-reset of the destination FIFO addressed
// by sel. The invalid address selects nothing (not empty, no soft reset).
module router_fsm_port_sel
  import router_pkg::*;
(
  input  logic [1:0] sel,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       target_empty,
  output logic       target_soft_reset
);

  // Per-destination flag mux.
  always_comb begin
    target_empty      = 1'b0;
    target_soft_reset = 1'b0;
    case (sel)
      ADDR_0: begin
        target_empty      = fifo_empty_0;
        target_soft_reset = soft_reset_0;
      end
      ADDR_1: begin
        target_empty      = fifo_empty_1;
        target_soft_reset = soft_reset_1;
      end
      ADDR_2: begin
        target_empty      = fifo_empty_2;
        target_soft_reset = soft_reset_2;
      end
      default: begin
        target_empty      = 1'b0;
        target_soft_reset = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/router_fsm.sv
// Packet-level controller of the 1x3 router: decodes the header address,
// waits for the target FIFO to drain, sequences header/payload/parity loads
// and decodes the Moore control strobes from the registered state.
// Optional feature macro: ROUTER_FSM_ADDR3_DROP_EN (silently drop packets
// addressed to 3 instead of idling in DECODE_ADDRESS).
module router_fsm
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg
);

  state_t     state;
  state_t     next_state;
  logic [1:0] addr_q;
  logic [1:0] sel;
  logic       target_empty;
  logic       target_soft_reset;

  // While decoding, the header is still on data_in and the latch is stale,
  // so the empty check must look at the live address.
  assign sel = (state == DECODE_ADDRESS) ? data_in : addr_q;

  router_fsm_port_sel u_port_sel (
    .sel               (sel),
    .fifo_empty_0      (fifo_empty_0),
    .fifo_empty_1      (fifo_empty_1),
    .fifo_empty_2      (fifo_empty_2),
    .soft_reset_0      (soft_reset_0),
    .soft_reset_1      (soft_reset_1),
    .soft_reset_2      (soft_reset_2),
    .target_empty      (target_empty),
    .target_soft_reset (target_soft_reset)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= DECODE_ADDRESS;
    else         state <= next_state;
  end

  // Target address latch: captured as the header is accepted, held until DA.
  always_ff @(posedge clk) begin
    if (!resetn)                                  addr_q <= ADDR_0;
    else if (state == DECODE_ADDRESS && pkt_valid) addr_q <= data_in;
  end

  // Next-state logic; a target soft reset outside DA overrides everything.
  always_comb begin
    next_state = state;
    if (target_soft_reset && state != DECODE_ADDRESS) begin
      next_state = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (pkt_valid) begin
            if (data_in != ADDR_INVALID)
              next_state = target_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
`ifdef ROUTER_FSM_ADDR3_DROP_EN
            else
              next_state = DROP_PACKET;
`endif
          end
        end
        WAIT_TILL_EMPTY:  if (target_empty) next_state = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA:  next_state = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       next_state = FIFO_FULL_STATE;
          else if (!pkt_valid) next_state = LOAD_PARITY;
        end
        FIFO_FULL_STATE:  if (!fifo_full) next_state = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (parity_done)        next_state = DECODE_ADDRESS;
          else if (low_pkt_valid) next_state = LOAD_PARITY;
          else                    next_state = LOAD_DATA;
        end
        LOAD_PARITY:        next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
`ifdef ROUTER_FSM_ADDR3_DROP_EN
        DROP_PACKET:        if (!pkt_valid) next_state = DECODE_ADDRESS;
`endif
        default:            next_state = DECODE_ADDRESS;
      endcase
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    busy          = 1'b0;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    case (state)
      DECODE_ADDRESS:  detect_add = 1'b1;
      WAIT_TILL_EMPTY: busy = 1'b1;
      LOAD_FIRST_DATA: begin
        busy          = 1'b1;
        lfd_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      FIFO_FULL_STATE: begin
        busy       = 1'b1;
        full_state = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        busy          = 1'b1;
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_PARITY: begin
        busy          = 1'b1;
        write_enb_reg = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        busy        = 1'b1;
        rst_int_reg = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed self-checking bench for router_fsm. Outputs are packed as
// {detect_add, busy, lfd_state, ld_state, laf_state, full_state,
//  write_enb_reg, rst_int_reg} and compared against per-state constants.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg;
  logic [7:0] outs;

  int passed = 0;
  int total  = 0;

  localparam logic [7:0] O_DA   = 8'b1000_0000;
  localparam logic [7:0] O_WTE  = 8'b0100_0000;
  localparam logic [7:0] O_LFD  = 8'b0110_0010;
  localparam logic [7:0] O_LD   = 8'b0001_0010;
  localparam logic [7:0] O_FFS  = 8'b0100_0100;
  localparam logic [7:0] O_LAF  = 8'b0100_1010;
  localparam logic [7:0] O_LP   = 8'b0100_0010;
  localparam logic [7:0] O_CPE  = 8'b0100_0001;
  localparam logic [7:0] O_DROP = 8'b0000_0000;

  always #5 clk = ~clk;

  assign outs = {detect_add, busy, lfd_state, ld_state, laf_state,
                 full_state, write_enb_reg, rst_int_reg};

  router_fsm dut (
    .clk           (clk),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .busy          (busy),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg)
  );

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pkt_valid     = 1'b0;
    data_in       = 2'd0;
    fifo_full     = 1'b0;
    fifo_empty_0  = 1'b1;
    fifo_empty_1  = 1'b1;
    fifo_empty_2  = 1'b1;
    soft_reset_0  = 1'b0;
    soft_reset_1  = 1'b0;
    soft_reset_2  = 1'b0;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    tick();
    tick();
    total++;
    if (outs !== O_DA) $display("FAIL reset_state got=%b exp=%b", outs, O_DA);
    else passed++;
    resetn = 1'b1;
    tick();
    total++;
    if (outs !== O_DA) $display("FAIL idle_da got=%b exp=%b", outs, O_DA);
    else passed++;
  endtask

  task automatic test_reset_mid_ld();
    pkt_valid = 1'b1; data_in = 2'd0;
    tick();
    tick();
    total++;
    if (outs !== O_LD) $display("FAIL pre_reset_ld got=%b exp=%b", outs, O_LD);
    else passed++;
    resetn = 1'b0;
    tick();
    tick();
    total++;
    if (outs !== O_DA) $display("FAIL reset_mid_ld got=%b exp=%b", outs, O_DA);
    else passed++;
    resetn = 1'b1;
    pkt_valid = 1'b0;
    tick();
  endtask

  task automatic test_basic_packet();
    int wr_cycles = 0;
    pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b1;
    tick();
    wr_cycles += int'(write_enb_reg);
    total++;
    if (outs !== O_LFD) $display("FAIL basic_lfd got=%b exp=%b", outs, O_LFD);
    else passed++;
    data_in = 2'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      wr_cycles += int'(write_enb_reg);
      total++;
      if (outs !== O_LD) $display("FAIL basic_ld%0d got=%b exp=%b", i, outs, O_LD);
      else passed++;
    end
    pkt_valid = 1'b0;
    tick();
    wr_cycles += int'(write_enb_reg);
    total++;
    if (outs !== O_LP) $display("FAIL basic_lp got=%b exp=%b", outs, O_LP);
    else passed++;
    tick();
    wr_cycles += int'(write_enb_reg);
    total++;
    if (outs !== O_CPE) $display("FAIL basic_cpe got=%b exp=%b", outs, O_CPE);
    else passed++;
    tick();
    wr_cycles += int'(write_enb_reg);
    total++;
    if (outs !== O_DA) $display("FAIL basic_da got=%b exp=%b", outs, O_DA);
    else passed++;
    total++;
    if (wr_cycles !== 6) $display("FAIL basic_wr_cycles got=%0d exp=6", wr_cycles);
    else passed++;
  endtask

  task automatic test_wait_empty();
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (outs !== O_WTE) $display("FAIL wte%0d got=%b exp=%b", i, outs, O_WTE);
      else passed++;
    end
    fifo_empty_2 = 1'b1;
    tick();
    total++;
    if (outs !== O_LFD) $display("FAIL wte_to_lfd got=%b exp=%b", outs, O_LFD);
    else passed++;
    pkt_valid = 1'b0;
    tick();   // LD
    tick();   // LP
    tick();   // CPE
    tick();
    total++;
    if (outs !== O_DA) $display("FAIL wte_pkt_end got=%b exp=%b", outs, O_DA);
    else passed++;
  endtask

  task automatic test_full_and_soft_reset();
    pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b1;
    tick();   // LFD
    tick();   // LD
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outs !== O_FFS) $display("FAIL ffs%0d got=%b exp=%b", i, outs, O_FFS);
      else passed++;
    end
    fifo_full = 1'b0;
    tick();
    total++;
    if (outs !== O_LAF) $display("FAIL laf got=%b exp=%b", outs, O_LAF);
    else passed++;
    tick();
    total++;
    if (outs !== O_LD) $display("FAIL laf_to_ld got=%b exp=%b", outs, O_LD);
    else passed++;
    fifo_full = 1'b1;
    tick();   // FFS
    soft_reset_1 = 1'b1;
    tick();
    soft_reset_1 = 1'b0;
    total++;
    if (outs !== O_FFS) $display("FAIL soft_reset_other got=%b exp=%b", outs, O_FFS);
    else passed++;
    soft_reset_0 = 1'b1;
    tick();
    soft_reset_0 = 1'b0;
    fifo_full = 1'b0;
    pkt_valid = 1'b0;
    total++;
    if (outs !== O_DA) $display("FAIL soft_reset_target got=%b exp=%b", outs, O_DA);
    else passed++;
  endtask

  task automatic test_priority();
    // LD: full and end-of-packet together -> full wins.
    pkt_valid = 1'b1; data_in = 2'd1;
    tick();   // LFD
    tick();   // LD
    pkt_valid = 1'b0; fifo_full = 1'b1;
    tick();
    total++;
    if (outs !== O_FFS) $display("FAIL prio_full_over_eop got=%b exp=%b", outs, O_FFS);
    else passed++;
    // LAF: parity_done and low_pkt_valid together -> DA.
    fifo_full = 1'b0;
    tick();   // LAF
    parity_done = 1'b1; low_pkt_valid = 1'b1;
    tick();
    total++;
    if (outs !== O_DA) $display("FAIL prio_parity_done got=%b exp=%b", outs, O_DA);
    else passed++;
    // LAF: low_pkt_valid alone -> LP.
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    pkt_valid = 1'b1;
    tick();   // LFD
    tick();   // LD
    fifo_full = 1'b1;
    tick();   // FFS
    fifo_full = 1'b0;
    tick();   // LAF
    low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    tick();
    low_pkt_valid = 1'b0;
    total++;
    if (outs !== O_LP) $display("FAIL laf_low_pkt_valid got=%b exp=%b", outs, O_LP);
    else passed++;
    // CPE with FIFO full -> FFS.
    fifo_full = 1'b1;
    tick();   // CPE
    tick();
    total++;
    if (outs !== O_FFS) $display("FAIL cpe_full got=%b exp=%b", outs, O_FFS);
    else passed++;
    fifo_full = 1'b0;
    soft_reset_1 = 1'b1;
    tick();
    soft_reset_1 = 1'b0;
    total++;
    if (outs !== O_DA) $display("FAIL prio_exit_da got=%b exp=%b", outs, O_DA);
    else passed++;
  endtask

  task automatic test_addr3();
    pkt_valid = 1'b1; data_in = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
`ifdef ROUTER_FSM_ADDR3_DROP_EN
      total++;
      if (outs !== O_DROP) $display("FAIL addr3_drop%0d got=%b exp=%b", i, outs, O_DROP);
      else passed++;
`else
      total++;
      if (outs !== O_DA) $display("FAIL addr3_da%0d got=%b exp=%b", i, outs, O_DA);
      else passed++;
`endif
    end
    pkt_valid = 1'b0; data_in = 2'd0;
    tick();
    total++;
    if (outs !== O_DA) $display("FAIL addr3_end got=%b exp=%b", outs, O_DA);
    else passed++;
  endtask

  task automatic test_back_to_back();
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b1;
    tick();   // LFD
    pkt_valid = 1'b0;
    tick();   // LD
    tick();   // LP
    tick();   // CPE
    tick();   // DA
    pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b1;
    tick();
    total++;
    if (outs !== O_LFD) $display("FAIL b2b_second_lfd got=%b exp=%b", outs, O_LFD);
    else passed++;
    pkt_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    total++;
    if (outs !== O_DA) $display("FAIL b2b_end got=%b exp=%b", outs, O_DA);
    else passed++;
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    test_reset();
    test_reset_mid_ld();
    test_basic_packet();
    test_wait_empty();
    test_full_and_soft_reset();
    test_priority();
    test_addr3();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
